// File: rtl/cpu8_service_loader_if.sv
// Host byte-stream link of the cpu8 service loader: command/payload bytes in,
// response and dump bytes out, each with a valid/ready handshake.
interface cpu8_service_loader_if;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;

   modport master (output rx_data, output rx_valid, input rx_ready,
                   input tx_data, input tx_valid, output tx_ready);
   modport slave  (input rx_data, input rx_valid, output rx_ready,
                   output tx_data, output tx_valid, input tx_ready);
endinterface

// File: rtl/cpu8_service_loader.sv
// Host-driven service loader for cpu8: loads program/data memory, dumps data memory,
// runs and halts the CPU. Define LOADER_CHECKSUM_EN to require a trailing checksum on loads.
module cpu8_service_loader (
   input  logic                        clk,
   input  logic                        rst,
   cpu8_service_loader_if.slave        host,
   output logic                        service_mode,
   output logic                        cpu_rst,
   output logic [7:0]                  program_memory_address,
   output logic [7:0]                  program_memory_data_in,
   output logic                        program_memory_write_enable,
   output logic [7:0]                  data_memory_address,
   output logic [7:0]                  data_memory_data_in,
   output logic                        data_memory_write_enable,
   input  logic [7:0]                  data_memory_data_out,
   output logic                        busy
);
   localparam logic [7:0] CMD_LOAD_PROG = 8'h01;
   localparam logic [7:0] CMD_LOAD_DATA = 8'h02;
   localparam logic [7:0] CMD_DUMP_DATA = 8'h03;
   localparam logic [7:0] CMD_RUN       = 8'h04;
   localparam logic [7:0] CMD_HALT      = 8'h05;
   localparam logic [7:0] STS_OK        = 8'hA5;
   localparam logic [7:0] STS_BAD_CMD   = 8'hE1;
   localparam logic [7:0] STS_BAD_SUM   = 8'hE2;

   typedef enum logic [3:0] {
      IDLE, GET_ADDR, GET_LEN, WRITE, RD_ADDR, RD_CAPTURE, SEND,
`ifdef LOADER_CHECKSUM_EN
      CHECK,
`endif
      STATUS, RUN_PULSE
   } state_t;

   typedef enum logic [1:0] {KIND_PROG, KIND_DATA, KIND_DUMP} kind_t;

`ifdef LOADER_CHECKSUM_EN
   localparam state_t AFTER_LOAD = CHECK;
   logic [7:0] sum;
`else
   localparam state_t AFTER_LOAD = STATUS;
`endif

   state_t     state, state_next;
   kind_t      kind;
   logic [7:0] addr;
   logic [8:0] remaining;
   logic       write_pending;
   logic       pulse_second;
   logic       started;
   logic [7:0] tx_data_q;
   logic       rx_ready_c, tx_valid_c, rx_fire, tx_fire, last_item;

   assign rx_fire       = host.rx_valid && rx_ready_c;
   assign tx_fire       = tx_valid_c && host.tx_ready;
   assign last_item     = (remaining == 9'd1);
   assign host.rx_ready = rx_ready_c;
   assign host.tx_valid = tx_valid_c;
   assign host.tx_data  = tx_data_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (rx_fire) begin
            case (host.rx_data)
               CMD_LOAD_PROG, CMD_LOAD_DATA, CMD_DUMP_DATA: state_next = GET_ADDR;
               CMD_RUN: state_next = RUN_PULSE;
               default: state_next = STATUS;
            endcase
         end
         GET_ADDR:   if (rx_fire) state_next = GET_LEN;
         GET_LEN:    if (rx_fire) state_next = (kind == KIND_DUMP) ? RD_ADDR : WRITE;
         WRITE:      if (write_pending && last_item) state_next = AFTER_LOAD;
         RD_ADDR:    state_next = RD_CAPTURE;
         RD_CAPTURE: state_next = SEND;
         SEND:       if (tx_fire) state_next = last_item ? STATUS : RD_ADDR;
`ifdef LOADER_CHECKSUM_EN
         CHECK:      if (rx_fire) state_next = STATUS;
`endif
         STATUS:     if (tx_fire) state_next = IDLE;
         RUN_PULSE:  if (pulse_second) state_next = STATUS;
         default:    state_next = IDLE;
      endcase
   end

   // rx_ready stays low until the first edge after reset; WRITE accepts only between strobes
   always_comb begin
      rx_ready_c = 1'b0;
      tx_valid_c = 1'b0;
      busy       = (state != IDLE);
      case (state)
         IDLE, GET_ADDR, GET_LEN: rx_ready_c = started;
         WRITE:                   rx_ready_c = !write_pending;
`ifdef LOADER_CHECKSUM_EN
         CHECK:                   rx_ready_c = 1'b1;
`endif
         SEND, STATUS:            tx_valid_c = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         started                     <= 1'b0;
         service_mode                <= 1'b1;
         cpu_rst                     <= 1'b1;
         kind                        <= KIND_PROG;
         addr                        <= 8'h00;
         remaining                   <= 9'd0;
         write_pending               <= 1'b0;
         pulse_second                <= 1'b0;
         tx_data_q                   <= 8'h00;
         program_memory_address      <= 8'h00;
         program_memory_data_in      <= 8'h00;
         program_memory_write_enable <= 1'b0;
         data_memory_address         <= 8'h00;
         data_memory_data_in         <= 8'h00;
         data_memory_write_enable    <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
         sum                         <= 8'h00;
`endif
      end else begin
         started                     <= 1'b1;
         cpu_rst                     <= 1'b0;
         pulse_second                <= 1'b0;
         program_memory_write_enable <= 1'b0;
         data_memory_write_enable    <= 1'b0;
         case (state)
            IDLE: if (rx_fire) begin
               case (host.rx_data)
                  CMD_LOAD_PROG: begin kind <= KIND_PROG; service_mode <= 1'b1; end
                  CMD_LOAD_DATA: begin kind <= KIND_DATA; service_mode <= 1'b1; end
                  CMD_DUMP_DATA: begin kind <= KIND_DUMP; service_mode <= 1'b1; end
                  CMD_RUN:  begin service_mode <= 1'b0; cpu_rst <= 1'b1; tx_data_q <= STS_OK; end
                  CMD_HALT: begin service_mode <= 1'b1; tx_data_q <= STS_OK; end
                  default:  tx_data_q <= STS_BAD_CMD;
               endcase
            end
            GET_ADDR: if (rx_fire) begin
               addr <= host.rx_data;
`ifdef LOADER_CHECKSUM_EN
               sum  <= host.rx_data;
`endif
            end
            GET_LEN: if (rx_fire) begin
               remaining <= (host.rx_data == 8'h00) ? 9'd256 : {1'b0, host.rx_data};
`ifdef LOADER_CHECKSUM_EN
               sum       <= sum + host.rx_data;
`endif
               if (kind == KIND_DUMP) data_memory_address <= addr;
            end
            // Accept a byte and latch the port, strobe on the following cycle, then advance
            WRITE: if (write_pending) begin
               write_pending <= 1'b0;
               addr          <= addr + 8'd1;
               remaining     <= remaining - 9'd1;
               if (last_item) tx_data_q <= STS_OK;
            end else if (rx_fire) begin
               write_pending <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
               sum           <= sum + host.rx_data;
`endif
               if (kind == KIND_PROG) begin
                  program_memory_address      <= addr;
                  program_memory_data_in      <= host.rx_data;
                  program_memory_write_enable <= 1'b1;
               end else begin
                  data_memory_address         <= addr;
                  data_memory_data_in         <= host.rx_data;
                  data_memory_write_enable    <= 1'b1;
               end
            end
            RD_CAPTURE: tx_data_q <= data_memory_data_out;
            SEND: if (tx_fire) begin
               addr      <= addr + 8'd1;
               remaining <= remaining - 9'd1;
               if (last_item) tx_data_q <= STS_OK;
               else           data_memory_address <= addr + 8'd1;
            end
`ifdef LOADER_CHECKSUM_EN
            CHECK: if (rx_fire)
               tx_data_q <= ((sum + host.rx_data) == 8'h00) ? STS_OK : STS_BAD_SUM;
`endif
            RUN_PULSE: begin
               cpu_rst      <= !pulse_second;
               pulse_second <= !pulse_second;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_cpu8_service_loader.sv
// Self-checking bench for cpu8_service_loader: command vector table, multi-cycle corner
// sequences and randomized commands against a behavioural model (honours LOADER_CHECKSUM_EN).
module tb_cpu8_service_loader;
   typedef struct packed { logic [7:0] addr; logic [7:0] data; } wr_t;
   typedef struct {
      logic [7:0] cmd;
      logic [7:0] exp_status;
      logic       exp_service_mode;
      int         exp_cpu_rst_cycles;
   } cmd_vec_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       service_mode, cpu_rst, busy, pm_we, dm_we;
   logic [7:0] pm_addr, pm_din, dm_addr, dm_din, dm_dout;

   int         n_checks = 0;
   int         n_fail = 0;
   int         cpu_rst_cycles = 0;
   int         ready_during_strobe = 0;
   int         tx_mode = 0;
   logic [7:0] data_mem [256];
   logic [7:0] model_data [256];
   logic [7:0] tx_q [$];
   wr_t        prog_q [$];
   wr_t        data_q [$];
   wr_t        exp_wr [$];
   cmd_vec_t   vec [7];
   logic [7:0] b;

   cpu8_service_loader_if host_bus ();

   cpu8_service_loader dut (
      .clk(clk), .rst(rst), .host(host_bus),
      .service_mode(service_mode), .cpu_rst(cpu_rst),
      .program_memory_address(pm_addr), .program_memory_data_in(pm_din),
      .program_memory_write_enable(pm_we),
      .data_memory_address(dm_addr), .data_memory_data_in(dm_din),
      .data_memory_write_enable(dm_we), .data_memory_data_out(dm_dout),
      .busy(busy)
   );

   always #5 clk = ~clk;

   // cpu8-side data memory with a registered read port
   always @(posedge clk) dm_dout <= data_mem[dm_addr];

   // Mid-cycle observer: every transfer or strobe seen here completes at the next rising edge
   always @(negedge clk) begin
      if (host_bus.tx_valid && host_bus.tx_ready) tx_q.push_back(host_bus.tx_data);
      if (pm_we) prog_q.push_back({pm_addr, pm_din});
      if (dm_we) begin
         data_q.push_back({dm_addr, dm_din});
         data_mem[dm_addr] = dm_din;
      end
      if ((pm_we || dm_we) && host_bus.rx_ready) ready_during_strobe++;
      if (rst && cpu_rst) cpu_rst_cycles++;
   end

   initial begin
      host_bus.tx_ready = 1'b1;
      forever begin
         @(posedge clk); #2;
         case (tx_mode)
            1:       host_bus.tx_ready = ~host_bus.tx_ready;
            2:       host_bus.tx_ready = 1'($urandom_range(0, 1));
            default: host_bus.tx_ready = 1'b1;
         endcase
      end
   end

   task automatic check_output(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) begin @(posedge clk); #2; end
   endtask

   // Offer one byte from just after a rising edge; returns just after the accepting edge
   task automatic apply_stimulus(input logic [7:0] value);
      bit got = 1'b0;
      host_bus.rx_data  = value;
      host_bus.rx_valid = 1'b1;
      for (int n = 0; n < 1000; n++) begin
         @(negedge clk);
         if (host_bus.rx_ready) begin got = 1'b1; break; end
      end
      @(posedge clk); #2;
      host_bus.rx_valid = 1'b0;
      if (!got) begin
         n_checks++; n_fail++;
         $display("[TB] FAIL rx_timeout: byte 0x%0h never accepted, expected acceptance", value);
      end
   endtask

   task automatic get_tx(output logic [7:0] value);
      bit got = 1'b0;
      value = 8'h00;
      for (int n = 0; n < 4000; n++) begin
         if (tx_q.size() > 0) begin got = 1'b1; break; end
         @(negedge clk); #1;
      end
      if (got) value = tx_q.pop_front();
      else begin
         n_checks++; n_fail++;
         $display("[TB] FAIL tx_timeout: no response byte, expected one");
      end
      @(posedge clk); #2;
   endtask

   task automatic clear_queues();
      tx_q.delete(); prog_q.delete(); data_q.delete(); exp_wr.delete();
   endtask

   task automatic check_writes(input string name, input bit is_prog);
      wr_t act [$];
      if (is_prog) act = prog_q;
      else         act = data_q;
      check_output({name, "_wr_count"}, act.size(), exp_wr.size());
      for (int i = 0; i < exp_wr.size() && i < act.size(); i++)
         check_output($sformatf("%s_wr%0d", name, i), 32'(act[i]), 32'(exp_wr[i]));
      if (is_prog) check_output({name, "_data_wr_count"}, data_q.size(), 0);
      else         check_output({name, "_prog_wr_count"}, prog_q.size(), 0);
   endtask

   // Reference model: op 1/2 load, op 3 dump; expectations follow the command rules directly
   task automatic run_command(input int it, input int op, input logic [7:0] start, input int len);
      logic [7:0] len_byte, a, v;
      logic [7:0] payload [$];
      logic [7:0] exp_tx [$];
      logic [7:0] exp_status;
`ifdef LOADER_CHECKSUM_EN
      logic [7:0] sum, chk;
`endif
      clear_queues();
      len_byte   = len[7:0];
      exp_status = 8'hA5;
      for (int i = 0; i < len; i++) begin
         a = start + 8'(i);
         if (op == 3) exp_tx.push_back(model_data[a]);
         else begin
            v = 8'($urandom);
            payload.push_back(v);
            exp_wr.push_back({a, v});
            if (op == 2) model_data[a] = v;
         end
      end
`ifdef LOADER_CHECKSUM_EN
      sum = start + len_byte;
      foreach (payload[i]) sum = sum + payload[i];
      chk = 8'h00 - sum;
      if (op != 3 && $urandom_range(0, 3) == 0) begin
         chk = chk + 8'h01;
         exp_status = 8'hE2;
      end
`endif
      exp_tx.push_back(exp_status);
      apply_stimulus(8'(op));
      apply_stimulus(start);
      apply_stimulus(len_byte);
      foreach (payload[i]) apply_stimulus(payload[i]);
`ifdef LOADER_CHECKSUM_EN
      if (op != 3) apply_stimulus(chk);
`endif
      foreach (exp_tx[i]) begin
         get_tx(v);
         check_output($sformatf("cmd%0d_op%0d_tx%0d", it, op, i), v, exp_tx[i]);
      end
      wait_cycles(3);
      check_output($sformatf("cmd%0d_extra_tx", it), tx_q.size(), 0);
      check_writes($sformatf("cmd%0d", it), op == 1);
   endtask

   initial begin
      host_bus.rx_valid = 1'b0;
      host_bus.rx_data  = 8'h00;
      for (int i = 0; i < 256; i++) begin
         data_mem[i]   = 8'(i * 7 + 3);
         model_data[i] = 8'(i * 7 + 3);
      end
      vec[0] = '{8'h7F, 8'hE1, 1'b1, 0};
      vec[1] = '{8'h04, 8'hA5, 1'b0, 2};
      vec[2] = '{8'h00, 8'hE1, 1'b0, 0};
      vec[3] = '{8'h05, 8'hA5, 1'b1, 0};
      vec[4] = '{8'hFF, 8'hE1, 1'b1, 0};
      vec[5] = '{8'h04, 8'hA5, 1'b0, 2};
      vec[6] = '{8'h06, 8'hE1, 1'b0, 0};

      // Reset values, then the first edge after release
      #1 rst = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_output("rst_service_mode", service_mode, 1);
      check_output("rst_cpu_rst", cpu_rst, 1);
      check_output("rst_tx_valid", host_bus.tx_valid, 0);
      check_output("rst_rx_ready", host_bus.rx_ready, 0);
      check_output("rst_busy", busy, 0);
      check_output("rst_write_enables", {pm_we, dm_we}, 0);
      check_output("rst_ports", {pm_addr, pm_din, dm_addr, dm_din}, 0);
      check_output("rst_tx_data", host_bus.tx_data, 0);
      @(posedge clk); #2;
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check_output("release_cpu_rst", cpu_rst, 0);
      check_output("release_rx_ready", host_bus.rx_ready, 1);
      check_output("release_service_mode", service_mode, 1);
      @(posedge clk); #2;

      // Single-byte commands from the vector table
      for (int i = 0; i < 7; i++) begin
         clear_queues();
         cpu_rst_cycles = 0;
         apply_stimulus(vec[i].cmd);
         get_tx(b);
         check_output($sformatf("vec%0d_status", i), b, vec[i].exp_status);
         wait_cycles(2);
         check_output($sformatf("vec%0d_service_mode", i), service_mode, vec[i].exp_service_mode);
         check_output($sformatf("vec%0d_cpu_rst_cycles", i), cpu_rst_cycles, vec[i].exp_cpu_rst_cycles);
         check_output($sformatf("vec%0d_busy", i), busy, 0);
         check_output($sformatf("vec%0d_no_writes", i), prog_q.size() + data_q.size(), 0);
      end

      // LOAD_PROG 0x10 len 3
      clear_queues();
      apply_stimulus(8'h01); apply_stimulus(8'h10); apply_stimulus(8'h03);
      apply_stimulus(8'hAA); apply_stimulus(8'hBB); apply_stimulus(8'hCC);
`ifdef LOADER_CHECKSUM_EN
      apply_stimulus(8'hBC);
`endif
      get_tx(b);
      check_output("load_prog_status", b, 8'hA5);
      exp_wr = '{16'h10AA, 16'h11BB, 16'h12CC};
      check_writes("load_prog", 1'b1);
      check_output("load_service_mode", service_mode, 1);

      // LOAD_DATA across the 0xFF/0x00 wrap, then dump it back with a toggling tx_ready
      clear_queues();
      apply_stimulus(8'h02); apply_stimulus(8'hFE); apply_stimulus(8'h03);
      apply_stimulus(8'h11); apply_stimulus(8'h22); apply_stimulus(8'h33);
`ifdef LOADER_CHECKSUM_EN
      apply_stimulus(8'h99);
`endif
      get_tx(b);
      check_output("load_wrap_status", b, 8'hA5);
      exp_wr = '{16'hFE11, 16'hFF22, 16'h0033};
      check_writes("load_wrap", 1'b0);
      model_data[8'hFE] = 8'h11; model_data[8'hFF] = 8'h22; model_data[8'h00] = 8'h33;
      clear_queues();
      tx_mode = 1;
      apply_stimulus(8'h03); apply_stimulus(8'hFE); apply_stimulus(8'h03);
      get_tx(b); check_output("dump_wrap_byte0", b, 8'h11);
      get_tx(b); check_output("dump_wrap_byte1", b, 8'h22);
      get_tx(b); check_output("dump_wrap_byte2", b, 8'h33);
      get_tx(b); check_output("dump_wrap_status", b, 8'hA5);
      check_writes("dump_wrap", 1'b0);
      tx_mode = 0;
      wait_cycles(2);

`ifdef LOADER_CHECKSUM_EN
      clear_queues();
      apply_stimulus(8'h01); apply_stimulus(8'h00); apply_stimulus(8'h01);
      apply_stimulus(8'h05); apply_stimulus(8'hFA);
      get_tx(b);
      check_output("checksum_good_status", b, 8'hA5);
      apply_stimulus(8'h01); apply_stimulus(8'h00); apply_stimulus(8'h01);
      apply_stimulus(8'h05); apply_stimulus(8'h00);
      get_tx(b);
      check_output("checksum_bad_status", b, 8'hE2);
      exp_wr = '{16'h0005, 16'h0005};
      check_writes("checksum", 1'b1);
`endif

      // Reset during the strobe cycle of an accepted payload byte
      clear_queues();
      apply_stimulus(8'h01); apply_stimulus(8'h30); apply_stimulus(8'h02);
      apply_stimulus(8'h44);
      check_output("abort_strobe_pending", pm_we, 1);
      rst = 1'b0;
      #1;
      check_output("abort_we_in_reset", pm_we, 0);
      check_output("abort_busy_in_reset", busy, 0);
      repeat (3) @(posedge clk);
      #2 rst = 1'b1;
      wait_cycles(12);
      check_output("abort_no_status", tx_q.size(), 0);
      check_output("abort_no_strobe", prog_q.size(), 0);
      check_output("abort_idle", busy, 0);
      check_output("abort_service_mode", service_mode, 1);
      apply_stimulus(8'h05);
      get_tx(b);
      check_output("abort_then_halt", b, 8'hA5);

      // Randomized commands with random tx backpressure, including full 256-byte transfers
      tx_mode = 2;
      for (int it = 0; it < 30; it++) begin
         int         op, len;
         logic [7:0] start;
         op    = $urandom_range(1, 3);
         start = 8'($urandom);
         len   = ($urandom_range(0, 15) == 0) ? 256 : $urandom_range(1, 8);
         if (it == 0) begin op = 2; start = 8'hC0; len = 256; end
         if (it == 1) begin op = 3; start = 8'hC0; len = 256; end
         run_command(it, op, start, len);
      end
      tx_mode = 0;

      check_output("rx_ready_during_strobe", ready_during_strobe, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
